// File: rtl/sixty_four_bit_seq_subtractor.sv
// 64-bit a - b computed as a + ~b + 1, one 16-bit chunk per cycle (LSB first).
// done pulses 5 cycles after the accepting edge; start is ignored while busy.
module sixty_four_bit_seq_subtractor (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] diff,
  output logic        cout,
  output logic        ovrflow
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [63:0] r_a;
  logic [63:0] r_b;
  logic [63:0] r_diff;
  logic        r_carry;
  logic        r_cout;
  logic        r_ovf;
  logic [1:0]  r_cnt;

  logic        w_accept;
  logic [15:0] w_a_chunk;
  logic [15:0] w_b_chunk;
  logic [16:0] w_sum;
  logic        w_d63;

  // DONE accepts a new start just like IDLE, giving back-to-back operation.
  assign w_accept  = start && (r_state != S_CALC);
  assign w_a_chunk = r_a[{r_cnt, 4'd0} +: 16];
  assign w_b_chunk = r_b[{r_cnt, 4'd0} +: 16];
  assign w_sum     = {1'b0, w_a_chunk} + {1'b0, ~w_b_chunk} + {16'd0, r_carry};
  assign w_d63     = w_sum[15];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (r_cnt == 2'd3) w_next = S_DONE;
      S_DONE:  w_next = start ? S_CALC : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_CALC);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_diff  <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= 2'd0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= 1'b1;
      r_cnt   <= 2'd0;
    end else if (r_state == S_CALC) begin
      r_diff[{r_cnt, 4'd0} +: 16] <= w_sum[15:0];
      r_carry <= w_sum[16];
      r_cnt   <= r_cnt + 2'd1;
      if (r_cnt == 2'd3) begin
        r_cout <= w_sum[16];
        r_ovf  <= (r_a[63] & ~r_b[63] & ~w_d63) | (~r_a[63] & r_b[63] & w_d63);
      end
    end
  end

  assign diff    = r_diff;
  assign cout    = r_cout;
  assign ovrflow = r_ovf;

endmodule

// File: doc/sixty_four_bit_seq_subtractor.md
SIXTY_FOUR_BIT_SEQ_SUBTRACTOR -- requirements
Module: sixty_four_bit_seq_subtractor

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (64-bit operands, 16-bit chunk per cycle).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only when busy=0.
REQ-005 a  input  64  minuend, two's complement; sampled with an accepted start.
REQ-006 b  input  64  subtrahend, two's complement; sampled with an accepted start.
REQ-007 busy  output  1  high while a subtraction is in progress.
REQ-008 done  output  1  single-cycle pulse marking valid results.
REQ-009 diff  output  64  registered result a - b, modulo 2^64.
REQ-010 cout  output  1  carry out of bit 63 of a + ~b + 1 (1 = no borrow, 0 = borrow).
REQ-011 ovrflow  output  1  signed overflow of a - b.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-013 IDLE: start=1 at a rising edge SHALL latch a and b, set the running carry to 1, clear the chunk counter to 0, and go to CALC.
REQ-014 CALC: each cycle SHALL compute one 16-bit chunk k (bits 16k+15:16k) as a_chunk + ~b_chunk + carry, write it into diff, and store that chunk's carry-out as the next carry.
REQ-015 CALC SHALL advance the counter 0,1,2,3; after chunk 3 is written it SHALL go to DONE.
REQ-016 On the chunk-3 edge, cout SHALL take the final carry-out and ovrflow SHALL take (a63 & ~b63 & ~d63) | (~a63 & b63 & d63), where d63 is the new diff[63] and a63/b63 are the latched operands.
REQ-017 busy SHALL be 1 exactly in CALC, i.e. 4 cycles starting the cycle after start is accepted.
REQ-018 done SHALL be 1 exactly in DONE, i.e. the 5th cycle after the accepting edge; latency from start edge to done = 5 cycles.
REQ-019 DONE SHALL return to IDLE after one cycle; start=1 during DONE SHALL be accepted exactly as in IDLE (back-to-back operation).
REQ-020 start during CALC SHALL be ignored; a and b changes during CALC SHALL not affect the result.
REQ-021 diff, cout and ovrflow SHALL hold their values from DONE until the first CALC edge of the next operation.
REQ-022 Partial diff values during CALC are not valid; consumers SHALL sample only when done=1.
REQ-023 Wrap-around: results SHALL be modulo 2^64; borrow is reported only through cout and never saturates.

Reset
REQ-024 reset=1 at a rising edge SHALL force IDLE, with busy=0, done=0, diff=0, cout=0, ovrflow=0, counter=0, and latched operands=0.
REQ-025 reset SHALL take priority over start and over any in-progress CALC; an aborted operation SHALL produce no done pulse.
REQ-026 The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-027 a=5, b=3, start for 1 cycle -> busy high for 4 cycles, then done=1 for 1 cycle with diff=0x2, cout=1, ovrflow=0.
REQ-028 a=0, b=1 -> diff=0xFFFF_FFFF_FFFF_FFFF, cout=0, ovrflow=0.
REQ-029 a=0x8000_0000_0000_0000, b=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, cout=1, ovrflow=1; a=0x7FFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF -> diff=0x8000_0000_0000_0000, cout=0, ovrflow=1.
REQ-030 a=0x0001_0000_0000_0000, b=1 (borrow through three chunk boundaries) -> diff=0x0000_FFFF_FFFF_FFFF, cout=1, ovrflow=0.
REQ-031 Start a=10,b=4; pulse start=1 with a=99,b=1 during CALC; assert start with a=7,b=7 in the DONE cycle -> first done gives diff=6; the mid-CALC start is ignored; the second done follows 5 cycles later with diff=0, cout=1.
REQ-032 reset asserted in the 2nd CALC cycle -> next cycle busy=0, done=0, diff=0, cout=0, ovrflow=0, and no done pulse appears; a following start with a=3,b=5 -> diff=0xFFFF_FFFF_FFFF_FFFE, cout=0.
